wb_interconnect_n: RTL and testbench

- Parametrised single-master, N-slave Wishbone (pipelined) interconnect. It is the successor to the fixed two-slave LED/CDT decoder.
- Per-slave base/mask address decode and single-outstanding-transaction tracking.
- Registered response mux and a timeout watchdog.
- Error reporting carries a cause code and the captured faulting address.
- Sits between the CPU Wishbone bridge and all SoC peripherals (SRAM, LEDs, UART, countdown timer).

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_addr_decode.sv | 30 +++
 rtl/wb_interconnect_n.sv | 178 +++++++++++++++++
 tb/tb_wb_interconnect_n.sv | 218 +++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared definitions for the N-slave Wishbone interconnect: error causes, FSM states
// and the default SoC address map.
package wb_pkg;

  localparam logic [1:0] WB_ERR_NONE     = 2'd0;
  localparam logic [1:0] WB_ERR_UNMAPPED = 2'd1;
  localparam logic [1:0] WB_ERR_SLAVE    = 2'd2;
  localparam logic [1:0] WB_ERR_TIMEOUT  = 2'd3;

  typedef enum logic [1:0] {
    StIdle    = 2'd0,
    StBusy    = 2'd1,
    StErrSend = 2'd2
  } wb_state_e;

  // Slot 0 sits in the low bits: SRAM, LED, UART, CDT.
  localparam int unsigned     WB_MAP_NS   = 4;
  localparam logic [127:0]    WB_MAP_BASE = {32'h8000_0010, 32'h8000_0008,
                                             32'h8000_0000, 32'h0000_0000};
  localparam logic [127:0]    WB_MAP_MASK = {32'hFFFF_FFF8, 32'hFFFF_FFF8,
                                             32'hFFFF_FFFC, 32'hFFFE_0000};

endpackage

// File: rtl/wb_addr_decode.sv
// Combinational base/mask address decoder; the lowest-indexed matching slave wins.
module wb_addr_decode #(
  parameter int unsigned        NS   = 4,
  parameter int unsigned        AW   = 32,
  parameter int unsigned        IW   = 2,
  parameter logic [NS*AW-1:0]   BASE = '0,
  parameter logic [NS*AW-1:0]   MASK = '1
) (
  input  logic [AW-1:0] i_addr,
  output logic [NS-1:0] o_sel,
  output logic [IW-1:0] o_idx,
  output logic          o_miss
);

  always_comb begin
    o_sel  = '0;
    o_idx  = '0;
    o_miss = 1'b1;
    // Scan downwards so a lower-indexed hit overrides any higher one.
    for (int k = NS - 1; k >= 0; k--) begin
      if ((i_addr & MASK[k*AW +: AW]) == (BASE[k*AW +: AW] & MASK[k*AW +: AW])) begin
        o_sel    = '0;
        o_sel[k] = 1'b1;
        o_idx    = IW'(k);
        o_miss   = 1'b0;
      end
    end
  end

endmodule

// File: rtl/wb_interconnect_n.sv
// Single-master, N-slave pipelined Wishbone interconnect with one outstanding transaction,
// registered response path, timeout watchdog and error cause/address capture.
module wb_interconnect_n
  import wb_pkg::*;
#(
  parameter int unsigned      NS         = 4,
  parameter int unsigned      AW         = 32,
  parameter int unsigned      DW         = 32,
  parameter logic [NS*AW-1:0] SLAVE_BASE = '0,
  parameter logic [NS*AW-1:0] SLAVE_MASK = '1,
  parameter int unsigned      TIMEOUT    = 255
) (
  input  logic                 i_clk,
  input  logic                 i_resetn,
  input  logic                 i_wb_cyc,
  input  logic                 i_wb_stb,
  input  logic                 i_wb_we,
  input  logic [AW-1:0]        i_wb_addr,
  input  logic [DW-1:0]        i_wb_data,
  input  logic [DW/8-1:0]      i_wb_sel,
  output logic                 o_wb_ack,
  output logic [DW-1:0]        o_wb_data,
  output logic                 o_wb_stall,
  output logic                 o_wb_err,
  output logic [AW-1:0]        o_wb_err_address,
  output logic [1:0]           o_wb_err_cause,
  output logic [NS-1:0]        o_s_cyc,
  output logic [NS-1:0]        o_s_stb,
  output logic                 o_s_we,
  output logic [AW-1:0]        o_s_addr,
  output logic [DW-1:0]        o_s_data,
  output logic [DW/8-1:0]      o_s_sel,
  input  logic [NS-1:0]        i_s_ack,
  input  logic [NS-1:0]        i_s_err,
  input  logic [NS-1:0]        i_s_stall,
  input  logic [NS*DW-1:0]     i_s_data
);

  localparam int unsigned IW = (NS > 1) ? $clog2(NS) : 1;
  localparam int unsigned CW = (TIMEOUT > 2) ? $clog2(TIMEOUT) : 1;

  wb_state_e       state_q, state_d;
  logic [IW-1:0]   grant_q, grant_d;
  logic [CW-1:0]   count_q, count_d;
  logic [AW-1:0]   pend_q, pend_d;
  logic            ack_q, ack_d;
  logic            err_q, err_d;
  logic [DW-1:0]   data_q, data_d;
  logic [AW-1:0]   err_addr_q, err_addr_d;
  logic [1:0]      cause_q, cause_d;

  logic [NS-1:0]   dec_sel;
  logic [IW-1:0]   dec_idx;
  logic            dec_miss;
  logic [NS-1:0]   gnt_oh;
  logic            accept;

  wb_addr_decode #(
    .NS   (NS),
    .AW   (AW),
    .IW   (IW),
    .BASE (SLAVE_BASE),
    .MASK (SLAVE_MASK)
  ) u_decode (
    .i_addr (i_wb_addr),
    .o_sel  (dec_sel),
    .o_idx  (dec_idx),
    .o_miss (dec_miss)
  );

  assign gnt_oh   = NS'(1) << grant_q;
  assign o_s_we   = i_wb_we;
  assign o_s_addr = i_wb_addr;
  assign o_s_data = i_wb_data;
  assign o_s_sel  = i_wb_sel;

  always_comb begin
    o_s_cyc    = '0;
    o_s_stb    = '0;
    o_wb_stall = 1'b1;
    unique case (state_q)
      StIdle: begin
        o_s_cyc    = {NS{i_wb_cyc}} & dec_sel;
        o_s_stb    = {NS{i_wb_cyc & i_wb_stb}} & dec_sel;
        o_wb_stall = i_wb_stb & ~dec_miss & |(i_s_stall & dec_sel);
      end
      StBusy:  o_s_cyc = {NS{i_wb_cyc}} & gnt_oh;
      default: ;
    endcase
  end

  assign accept = (state_q == StIdle) & i_wb_cyc & i_wb_stb & ~o_wb_stall;

  always_comb begin
    state_d    = state_q;
    grant_d    = grant_q;
    count_d    = count_q;
    pend_d     = pend_q;
    ack_d      = 1'b0;
    err_d      = 1'b0;
    data_d     = '0;
    err_addr_d = err_addr_q;
    cause_d    = cause_q;
    unique case (state_q)
      StIdle: begin
        if (accept) begin
          pend_d = i_wb_addr;
          if (dec_miss) begin
            state_d = StErrSend;
          end else begin
            state_d = StBusy;
            grant_d = dec_idx;
            count_d = '0;
          end
        end
      end
      StErrSend: begin
        state_d    = StIdle;
        err_d      = 1'b1;
        cause_d    = WB_ERR_UNMAPPED;
        err_addr_d = pend_q;
      end
      StBusy: begin
        if (!i_wb_cyc) begin
          state_d = StIdle;
        end else if (|(i_s_err & gnt_oh)) begin
          state_d    = StIdle;
          err_d      = 1'b1;
          cause_d    = WB_ERR_SLAVE;
          err_addr_d = pend_q;
        end else if (|(i_s_ack & gnt_oh)) begin
          state_d = StIdle;
          ack_d   = 1'b1;
          data_d  = i_s_data[grant_q*DW +: DW];
        end else if (count_q == CW'(TIMEOUT - 1)) begin
          state_d    = StIdle;
          err_d      = 1'b1;
          cause_d    = WB_ERR_TIMEOUT;
          err_addr_d = pend_q;
        end else if (count_q != '1) begin
          count_d = count_q + 1'b1;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge i_clk or negedge i_resetn) begin
    if (!i_resetn) begin
      state_q    <= StIdle;
      grant_q    <= '0;
      count_q    <= '0;
      pend_q     <= '0;
      ack_q      <= 1'b0;
      err_q      <= 1'b0;
      data_q     <= '0;
      err_addr_q <= '0;
      cause_q    <= WB_ERR_NONE;
    end else begin
      state_q    <= state_d;
      grant_q    <= grant_d;
      count_q    <= count_d;
      pend_q     <= pend_d;
      ack_q      <= ack_d;
      err_q      <= err_d;
      data_q     <= data_d;
      err_addr_q <= err_addr_d;
      cause_q    <= cause_d;
    end
  end

  assign o_wb_ack         = ack_q;
  assign o_wb_err         = err_q;
  assign o_wb_data        = data_q;
  assign o_wb_err_address = err_addr_q;
  assign o_wb_err_cause   = cause_q;

endmodule

// File: tb/tb_wb_interconnect_n.sv
// Scoreboard bench for wb_interconnect_n on the default SoC map with a short watchdog.
module tb_wb_interconnect_n;
  import wb_pkg::*;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          wb_cyc, wb_stb, wb_we;
  logic [31:0]   wb_addr, wb_wdata;
  logic [3:0]    wb_sel;
  logic          wb_ack, wb_stall, wb_err;
  logic [31:0]   wb_rdata, err_addr;
  logic [1:0]    err_cause;
  logic [3:0]    s_cyc, s_stb;
  logic          s_we;
  logic [31:0]   s_addr, s_wdata;
  logic [3:0]    s_sel;
  logic [3:0]    s_ack, s_err, s_stall;
  logic [127:0]  s_rdata;

  typedef struct {
    bit          is_err;
    logic [31:0] data;
    logic [1:0]  cause;
    logic [31:0] addr;
    int          cyc;
  } exp_t;

  exp_t exp_q[$];
  exp_t e;
  int   cyc_n   = 0;
  int   n_check = 0;
  int   n_pass  = 0;
  int   c;

  wb_interconnect_n #(
    .NS         (WB_MAP_NS),
    .AW         (32),
    .DW         (32),
    .SLAVE_BASE (WB_MAP_BASE),
    .SLAVE_MASK (WB_MAP_MASK),
    .TIMEOUT    (8)
  ) dut (
    .i_clk            (clk),
    .i_resetn         (rst_n),
    .i_wb_cyc         (wb_cyc),
    .i_wb_stb         (wb_stb),
    .i_wb_we          (wb_we),
    .i_wb_addr        (wb_addr),
    .i_wb_data        (wb_wdata),
    .i_wb_sel         (wb_sel),
    .o_wb_ack         (wb_ack),
    .o_wb_data        (wb_rdata),
    .o_wb_stall       (wb_stall),
    .o_wb_err         (wb_err),
    .o_wb_err_address (err_addr),
    .o_wb_err_cause   (err_cause),
    .o_s_cyc          (s_cyc),
    .o_s_stb          (s_stb),
    .o_s_we           (s_we),
    .o_s_addr         (s_addr),
    .o_s_data         (s_wdata),
    .o_s_sel          (s_sel),
    .i_s_ack          (s_ack),
    .i_s_err          (s_err),
    .i_s_stall        (s_stall),
    .i_s_data         (s_rdata)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc_n <= cyc_n + 1;

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] want);
    n_check++;
    if (got === want) n_pass++;
    else $display("FAIL %s: got %h required %h (cycle %0d)", name, got, want, cyc_n);
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Monitor: every response the DUT presents must match the head of the scoreboard.
  always @(negedge clk) begin
    if (rst_n) begin
      if (wb_ack || wb_err) begin
        chk("ack_err_exclusive", {31'd0, wb_ack & wb_err}, 32'd0);
        if (exp_q.size() == 0) begin
          n_check++;
          $display("FAIL unexpected_response: ack=%0b err=%0b with empty queue (cycle %0d)",
                   wb_ack, wb_err, cyc_n);
        end else begin
          e = exp_q.pop_front();
          chk("resp_cycle", cyc_n, e.cyc);
          chk("resp_is_err", {31'd0, wb_err}, {31'd0, e.is_err});
          if (e.is_err) begin
            chk("err_cause", {30'd0, err_cause}, {30'd0, e.cause});
            chk("err_address", err_addr, e.addr);
          end else begin
            chk("ack_data", wb_rdata, e.data);
          end
        end
      end else begin
        chk("data_zero_no_ack", wb_rdata, 32'd0);
      end
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1, "watchdog expired");
  end

  initial begin
    rst_n = 1'b0; wb_cyc = 0; wb_stb = 0; wb_we = 0; wb_addr = '0; wb_wdata = '0;
    wb_sel = 4'hF; s_ack = '0; s_err = '0; s_stall = '0; s_rdata = '0;
    #3;
    chk("rst_ack", {31'd0, wb_ack}, 32'd0);
    chk("rst_err", {31'd0, wb_err}, 32'd0);
    chk("rst_data", wb_rdata, 32'd0);
    chk("rst_cause", {30'd0, err_cause}, 32'd0);
    chk("rst_addr", err_addr, 32'd0);
    tick; tick;
    rst_n = 1'b1;
    tick;

    // CDT read, ack two cycles after the strobe.
    c = cyc_n;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 32'h8000_0010;
    #1 chk("t1_stb", {28'd0, s_stb}, 32'h8);
    exp_q.push_back('{1'b0, 32'hDEAD_BEEF, 2'd0, 32'h0, c + 3});
    tick; wb_stb = 0;
    #1 chk("t1_stb_drop", {28'd0, s_stb}, 32'h0);
    chk("t1_cyc_grant", {28'd0, s_cyc}, 32'h8);
    tick; s_ack = 4'b1000; s_rdata[96 +: 32] = 32'hDEAD_BEEF;
    tick; s_ack = '0;
    tick; wb_cyc = 0;
    tick;

    // Unmapped write.
    c = cyc_n;
    wb_cyc = 1; wb_stb = 1; wb_we = 1; wb_addr = 32'h9000_0000;
    #1 chk("t2_no_stb", {28'd0, s_stb}, 32'h0);
    exp_q.push_back('{1'b1, 32'h0, WB_ERR_UNMAPPED, 32'h9000_0000, c + 2});
    tick; wb_stb = 0;
    tick; tick; wb_cyc = 0;
    tick;

    // LED never responds: timeout, then a normal LED access.
    c = cyc_n;
    wb_cyc = 1; wb_stb = 1; wb_we = 0; wb_addr = 32'h8000_0000;
    exp_q.push_back('{1'b1, 32'h0, WB_ERR_TIMEOUT, 32'h8000_0000, c + 9});
    tick; wb_stb = 0;
    repeat (9) tick;
    wb_stb = 1;
    exp_q.push_back('{1'b0, 32'h1234_5678, 2'd0, 32'h0, c + 12});
    tick; wb_stb = 0; s_ack = 4'b0010; s_rdata[32 +: 32] = 32'h1234_5678;
    tick; s_ack = '0;
    tick;
    chk("t3_cause_held", {30'd0, err_cause}, {30'd0, WB_ERR_TIMEOUT});
    chk("t3_addr_held", err_addr, 32'h8000_0000);
    wb_cyc = 0;
    tick;

    // UART raises err and ack together: err wins.
    c = cyc_n;
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h8000_0008;
    tick; wb_stb = 0; s_ack = 4'b0100; s_err = 4'b0100;
    exp_q.push_back('{1'b1, 32'h0, WB_ERR_SLAVE, 32'h8000_0008, c + 2});
    tick; s_ack = '0; s_err = '0;
    tick; wb_cyc = 0;
    tick;

    // SRAM stalls for three cycles.
    c = cyc_n;
    s_stall = 4'b0001;
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h0000_0100;
    #1 chk("t5_stall_c0", {31'd0, wb_stall}, 32'd1);
    tick; #1 chk("t5_stall_c1", {31'd0, wb_stall}, 32'd1);
    tick; #1 chk("t5_stall_c2", {31'd0, wb_stall}, 32'd1);
    tick; s_stall = '0;
    #1 chk("t5_stall_release", {31'd0, wb_stall}, 32'd0);
    exp_q.push_back('{1'b0, 32'hCAFE_0000, 2'd0, 32'h0, c + 5});
    tick; wb_stb = 0; s_ack = 4'b0001; s_rdata[0 +: 32] = 32'hCAFE_0000;
    tick; s_ack = '0;
    tick; wb_cyc = 0;
    tick;

    // Abort in BUSY, then a late LED ack must be ignored.
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h8000_0000;
    tick; wb_cyc = 0; wb_stb = 0;
    #1 chk("t6_cyc_drop", {28'd0, s_cyc}, 32'h0);
    tick; s_ack = 4'b0010;
    #1 chk("t6_idle_stall", {31'd0, wb_stall}, 32'd0);
    tick; s_ack = '0;
    tick; tick;

    // Asynchronous reset while BUSY.
    wb_cyc = 1; wb_stb = 1; wb_addr = 32'h8000_0010;
    tick; wb_stb = 0;
    #1 chk("t7_busy_cyc", {28'd0, s_cyc}, 32'h8);
    chk("t7_busy_stall", {31'd0, wb_stall}, 32'd1);
    #1 rst_n = 1'b0;
    #1 chk("t7_rst_stall", {31'd0, wb_stall}, 32'd0);
    chk("t7_rst_cause", {30'd0, err_cause}, 32'd0);
    chk("t7_rst_addr", err_addr, 32'd0);
    chk("t7_rst_ack", {31'd0, wb_ack}, 32'd0);
    wb_cyc = 0;
    tick; rst_n = 1'b1;
    tick; tick; tick;

    chk("queue_drained", exp_q.size(), 32'd0);
    $display("%0d/%0d checks passed", n_pass, n_check);
    $finish;
  end

endmodule
